// File: rtl/inst_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
//   Shared constants for the instruction fetch controller:
//   - InstAddrBus / InstBus : CPU fetch-port address and instruction widths
//   - FILL_LEN              : bytes fetched per word fill
//   - fetch_state_t         : fill FSM state encoding
// ----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    // One word is assembled from FILL_LEN byte reads.
    localparam int FILL_LEN = 4;
    localparam int CNT_W    = $clog2(FILL_LEN);
    localparam int WORD_W   = InstAddrBus - CNT_W;   // width of a word address (tag)

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage : inst_fetch_ctrl_pkg

// File: rtl/inst_fetch_buf.sv
// ----------------------------------------------------------------------------
// inst_fetch_buf
//   One-word instruction buffer (data, tag, valid) with hit compare.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     ce              : fetch enable from the CPU
//     addr_word       : requested word address (byte address [31:2])
//     byte_we         : write byte_in into the data lane selected by byte_off
//     byte_off        : byte offset within the word (0 = most significant)
//     byte_in         : byte returned from memory
//     fill_start      : a fill begins; buffer contents become untrustworthy
//     fill_done       : last byte lands this edge; mark valid with fill_word
//     fill_word       : word address of the fill in progress
//     inv             : invalidate the buffer at the next edge
//     hit             : ce && valid && tag match (combinational)
//     data            : buffered word
// ----------------------------------------------------------------------------
module inst_fetch_buf
    import inst_fetch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [WORD_W-1:0]  addr_word,
    input  logic               byte_we,
    input  logic [CNT_W-1:0]   byte_off,
    input  logic [7:0]         byte_in,
    input  logic               fill_start,
    input  logic               fill_done,
    input  logic [WORD_W-1:0]  fill_word,
    input  logic               inv,
    output logic               hit,
    output logic [InstBus-1:0] data
);

    logic [WORD_W-1:0] tag;
    logic              valid;

    assign hit = ce && valid && (addr_word == tag);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data word is a single register, not a RAM, so it is
            // cleared on reset along with tag and valid.
            data  <= '0;
            tag   <= '0;
            valid <= 1'b0;
        end else begin
            // Big-endian: offset k lands in the k-th byte from the top.
            if (byte_we)
                data[(InstBus - 1) - 8 * int'(byte_off) -: 8] <= byte_in;

            if (fill_done)
                tag <= fill_word;

            // Valid drops for the whole fill so a half-written word never hits;
            // an invalidate in the completing cycle discards the fill.
            if (inv || fill_start)
                valid <= 1'b0;
            else if (fill_done)
                valid <= 1'b1;
        end
    end

endmodule : inst_fetch_buf

// File: rtl/inst_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Responder end of the CPU instruction fetch port. Serves 32-bit words out
//   of a one-word buffer, refilling it from a byte-wide memory on a miss.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     ce           : fetch enable
//     addr         : instruction byte address ([1:0] ignored)
//     inst         : instruction (buffer data on hit, 0 otherwise)
//     stall_req    : high while ce=1 and the word is not available
//     inv          : invalidate the buffer
//     mem_addr_o   : byte address to instruction memory
//     mem_re_o     : byte read strobe; data returns one cycle later
//     mem_data_i   : byte read data
// ----------------------------------------------------------------------------
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [InstAddrBus-1:0] addr,
    output logic [InstBus-1:0]     inst,
    output logic                   stall_req,
    input  logic                   inv,
    output logic [InstAddrBus-1:0] mem_addr_o,
    output logic                   mem_re_o,
    input  logic [7:0]             mem_data_i
);

    fetch_state_t       state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [WORD_W-1:0]  fill_word;
    logic [WORD_W-1:0]  addr_word;
    logic               rd_pend;     // a strobe was issued last cycle
    logic [CNT_W-1:0]   rd_off;      // offset of that strobe
    logic               hit;
    logic               fill_start;
    logic               fill_done;
    logic [InstBus-1:0] buf_data;
    logic               unused_addr_lsb;

    assign addr_word       = addr[InstAddrBus-1:CNT_W];
    assign unused_addr_lsb = ^addr[CNT_W-1:0];
    assign cnt_nxt         = cnt + 1'b1;

    assign fill_start = (state == ST_IDLE) && ce && !hit;
    assign fill_done  = (state == ST_DONE);

    assign inst      = hit ? buf_data : '0;
    assign stall_req = ce && !hit;

    inst_fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr_word  (addr_word),
        .byte_we    (rd_pend),
        .byte_off   (rd_off),
        .byte_in    (mem_data_i),
        .fill_start (fill_start),
        .fill_done  (fill_done),
        .fill_word  (fill_word),
        .inv        (inv),
        .hit        (hit),
        .data       (buf_data)
    );

    // Memory strobe/address are registered: they are set up on the edge that
    // enters (or advances within) FILL and cleared on the edge leaving it.
    // rd_pend/rd_off follow the strobe by one cycle to mark the returning byte;
    // clearing them on reset discards a byte still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            fill_word  <= '0;
            mem_re_o   <= 1'b0;
            mem_addr_o <= '0;
            rd_pend    <= 1'b0;
            rd_off     <= '0;
        end else begin
            rd_pend <= mem_re_o;
            rd_off  <= cnt;

            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        state      <= ST_FILL;
                        fill_word  <= addr_word;
                        cnt        <= '0;
                        mem_re_o   <= 1'b1;
                        mem_addr_o <= {addr_word, {CNT_W{1'b0}}};
                    end
                end
                ST_FILL: begin
                    if (cnt == CNT_LAST) begin
                        state      <= ST_DONE;
                        mem_re_o   <= 1'b0;
                        mem_addr_o <= '0;
                    end else begin
                        cnt        <= cnt_nxt;
                        mem_addr_o <= {fill_word, cnt_nxt};
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_re_o   <= 1'b0;
                    mem_addr_o <= '0;
                end
            endcase
        end
    end

endmodule : inst_fetch_ctrl

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        inv;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        stall_req;
    logic [31:0] mem_addr_o;
    logic        mem_re_o;
    logic [7:0]  mem_data_i;

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr       (addr),
        .inst       (inst),
        .stall_req  (stall_req),
        .inv        (inv),
        .mem_addr_o (mem_addr_o),
        .mem_re_o   (mem_re_o),
        .mem_data_i (mem_data_i)
    );

    // Byte-wide memory: data valid the cycle after the strobe, garbage otherwise.
    logic [7:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_re_o)
            mem_data_i <= mem[mem_addr_o[7:0]];
        else
            mem_data_i <= 8'($urandom);
    end

    // Reference model: buffer contents plus a "fill in flight since cycle N".
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          armed = 1'b0;
    bit          m_busy = 1'b0;
    int          m_start = 0;
    logic [29:0] m_fill = '0;
    bit          m_valid = 1'b0;
    logic [29:0] m_tag = '0;
    logic [31:0] m_data = '0;

    function automatic logic [31:0] word_at(logic [29:0] w);
        logic [7:0] base;
        base = {w[5:0], 2'd0};
        return {mem[base], mem[base + 8'd1], mem[base + 8'd2], mem[base + 8'd3]};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Apply one cycle of inputs and compare the settled outputs with the model.
    task automatic drive(bit r, bit c, logic [31:0] a, bit i);
        int          ph;
        bit          exp_hit;
        bit          exp_stall;
        bit          exp_re;
        logic [31:0] exp_addr;
        rst  = r;
        ce   = c;
        addr = a;
        inv  = i;
        @(negedge clk);
        if (armed) begin
            ph = cyc - m_start;
            if (m_busy) begin
                exp_hit   = 1'b0;
                exp_stall = c;
                exp_re    = (ph <= 4);
                exp_addr  = (ph <= 4) ? {m_fill, 2'(ph - 1)} : 32'h0;
            end else begin
                exp_hit   = c && m_valid && (a[31:2] == m_tag);
                exp_stall = c && !exp_hit;
                exp_re    = 1'b0;
                exp_addr  = 32'h0;
            end
            check("stall_req", 32'(stall_req), 32'(exp_stall));
            check("mem_re_o", 32'(mem_re_o), 32'(exp_re));
            check("mem_addr_o", mem_addr_o, exp_addr);
            if (!c || exp_hit)
                check("inst", inst, exp_hit ? m_data : 32'h0);
        end
    endtask

    // Clock edge: advance the model with the inputs the DUT just sampled.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_tag   = '0;
            m_data  = '0;
            armed   = 1'b1;
        end else if (m_busy) begin
            if (cyc - m_start == 5) begin
                m_busy  = 1'b0;
                m_valid = !inv;
                m_tag   = m_fill;
                m_data  = word_at(m_fill);
            end
        end else if (ce && !(m_valid && addr[31:2] == m_tag)) begin
            m_busy  = 1'b1;
            m_start = cyc;
            m_fill  = addr[31:2];
            m_valid = 1'b0;
        end else if (inv) begin
            m_valid = 1'b0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        bit          rr, rc, ri;

        rst = 1'b1; ce = 1'b0; inv = 1'b0; addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[4] = 8'h34; mem[5] = 8'h02; mem[6] = 8'h00; mem[7] = 8'h20;

        // Reset
        drive(1, 0, 32'h0, 0); tick();
        drive(1, 0, 32'h0, 0); tick();
        drive(0, 0, 32'h0, 0);
        check("reset_inst", inst, 32'h0);
        check("reset_re", 32'(mem_re_o), 32'h0);
        tick();

        // Cold miss on word 4
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 32'h4, 0);
            check("cold_stall", 32'(stall_req), 32'h1);
            if (k >= 1 && k <= 4) check("cold_strobe_addr", mem_addr_o, 32'(4 + k - 1));
            tick();
        end
        drive(0, 1, 32'h4, 0);
        check("cold_inst", inst, 32'h34020020);
        check("cold_stall_done", 32'(stall_req), 32'h0);
        tick();

        // Hit within the same word
        drive(0, 1, 32'h6, 0);
        check("hit_inst", inst, 32'h34020020);
        check("hit_re", 32'(mem_re_o), 32'h0);
        tick();

        // Address change mid-fill: word 4 completes, then word 8 is filled
        drive(0, 0, 32'h4, 1); tick();
        for (int k = 0; k <= 12; k++) begin
            drive(0, 1, (k < 2) ? 32'h4 : 32'h8, 0);
            if (k >= 7 && k <= 10) check("chg_strobe_addr", mem_addr_o, 32'(8 + k - 7));
            if (k == 12) begin
                check("chg_inst", inst, word_at(30'd2));
                check("chg_stall", 32'(stall_req), 32'h0);
            end
            tick();
        end

        // Invalidate while hitting
        for (int k = 0; k <= 6; k++) begin
            drive(0, 1, 32'h4, 0); tick();
        end
        drive(0, 1, 32'h4, 1);
        check("inv_hit_stall", 32'(stall_req), 32'h0);
        tick();
        drive(0, 1, 32'h4, 0);
        check("inv_miss_stall", 32'(stall_req), 32'h1);
        tick();
        for (int k = 1; k <= 6; k++) begin
            drive(0, 1, 32'h4, 0);
            if (k <= 4) check("inv_refill_re", 32'(mem_re_o), 32'h1);
            tick();
        end

        // Invalidate coinciding with DONE
        drive(0, 0, 32'h4, 1); tick();
        for (int k = 0; k <= 5; k++) begin
            drive(0, 1, 32'h4, k == 5); tick();
        end
        drive(0, 1, 32'h4, 0);
        check("inv_done_stall", 32'(stall_req), 32'h1);
        tick();
        for (int k = 1; k <= 6; k++) begin
            drive(0, 1, 32'h4, 0);
            if (k == 6) check("inv_done_refill_inst", inst, 32'h34020020);
            tick();
        end

        // Reset in cycle 3 of a fill
        drive(0, 0, 32'h4, 1); tick();
        for (int k = 0; k <= 2; k++) begin
            drive(0, 1, 32'h4, 0); tick();
        end
        drive(1, 1, 32'h4, 0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 32'h4, 0);
            check("rst_mid_re", 32'(mem_re_o), 32'h0);
            tick();
        end
        for (int k = 0; k <= 6; k++) begin
            drive(0, 1, 32'h4, 0);
            if (k == 0) check("rst_refill_stall", 32'(stall_req), 32'h1);
            if (k == 1) check("rst_refill_re", 32'(mem_re_o), 32'h1);
            if (k == 6) check("rst_refill_inst", inst, 32'h34020020);
            tick();
        end

        // Randomized traffic over a handful of words
        ra = 32'h4;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                ra = {24'h0, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 3'b0} >> 1;
            rr = ($urandom_range(0, 99) == 0);
            rc = ($urandom_range(0, 9) != 0);
            ri = ($urandom_range(0, 29) == 0);
            drive(rr, rc, ra, ri);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_inst_fetch_ctrl
